// File: rtl/rx_fcs_check_pkg.sv
// Shared constants, state encoding and the dibit CRC-32 step for the RX FCS checker.
package rx_fcs_check_pkg;

  localparam logic [31:0] CRC_INIT    = 32'hffffffff;
  localparam logic [31:0] CRC_POLY    = 32'hedb88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hdebb20e3;
  localparam int unsigned FCS_DIBITS  = 16;
  localparam int unsigned FILL_W      = $clog2(FCS_DIBITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } state_t;

  // Two reflected divisions, earlier bit (d[0]) first.
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] s;
    s = {c[31:2], c[1:0] ^ d};
    s = (s >> 1) ^ (s[0] ? CRC_POLY : '0);
    s = (s >> 1) ^ (s[0] ? CRC_POLY : '0);
    return s;
  endfunction

endpackage

// File: rtl/rx_fcs_check_if.sv
// Dibit stream in, stripped payload stream and per-frame status out.
interface rx_fcs_check_if #(
  parameter int unsigned LEN_W = 11
);
  logic             in_vld;
  logic [1:0]       in;
  logic             in_done;
  logic             out_vld;
  logic [1:0]       out;
  logic             frame_end;
  logic             fcs_ok;
  logic             runt;
  logic             align_err;
  logic             too_long;
  logic [LEN_W-1:0] len;

  modport master (
    output in_vld, in, in_done,
    input  out_vld, out, frame_end, fcs_ok, runt, align_err, too_long, len
  );

  modport slave (
    input  in_vld, in, in_done,
    output out_vld, out, frame_end, fcs_ok, runt, align_err, too_long, len
  );
endinterface

// File: rtl/rx_fcs_check_dibit_delay16.sv
// 16-dibit delay line holding back the FCS; fill counts accepted dibits up to 16.
module dibit_delay16
  import rx_fcs_check_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift,
  input  logic [1:0]        din,
  output logic [1:0]        dout,
  output logic [FILL_W-1:0] fill
);

  logic [2*FCS_DIBITS-1:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr   <= '0;
      fill <= '0;
    end else begin
      if (shift) sr <= {sr[2*FCS_DIBITS-3:0], din};
      if (clear) fill <= '0;
      else if (shift && fill != FILL_W'(FCS_DIBITS)) fill <= fill + 1'b1;
    end
  end

  assign dout = sr[2*FCS_DIBITS-1 -: 2];

endmodule

// File: rtl/rx_fcs_check.sv
// RX FCS checker: strips the trailing 4-byte FCS, streams payload dibits, and
// reports residue check, length, runt, alignment and too-long once per frame.
module rx_fcs_check
  import rx_fcs_check_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 2047,
  parameter int unsigned LEN_W     = 11
) (
  input logic          clk,
  input logic          reset,
  rx_fcs_check_if.slave bus
);

  state_t            state;
  logic [31:0]       crc;
  logic [31:0]       crc_next;
  logic [1:0]        phase;
  logic [1:0]        phase_next;
  logic [LEN_W-1:0]  len_cnt;
  logic [LEN_W-1:0]  len_next;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_next;
  logic [1:0]        dly_out;
  logic              emit;
  logic              finish;
  logic              runt_next;
  logic              align_next;

  dibit_delay16 u_delay (
    .clk   (clk),
    .reset (reset),
    .clear (finish),
    .shift (bus.in_vld),
    .din   (bus.in),
    .dout  (dly_out),
    .fill  (fill)
  );

  // The same-cycle dibit is folded into every *_next value so in_done
  // coincident with the last dibit sees the complete frame.
  always_comb begin
    emit       = (state == STREAM) && bus.in_vld;
    finish     = bus.in_done && ((state != IDLE) || bus.in_vld);
    crc_next   = crc;
    if (bus.in_vld) crc_next = crc_dibit((state == IDLE) ? CRC_INIT : crc, bus.in);
    fill_next  = fill;
    if (bus.in_vld && fill != FILL_W'(FCS_DIBITS)) fill_next = fill + 1'b1;
    phase_next = phase + {1'b0, bus.in_vld};
    len_next   = len_cnt;
    // Exactly 16 dibits are buffered, so the emitted dibit shares the input phase.
    if (emit && phase == 2'd3 && len_cnt != LEN_W'(MAX_BYTES)) len_next = len_cnt + 1'b1;
    runt_next  = fill_next < FILL_W'(FCS_DIBITS);
    align_next = phase_next != 2'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      crc           <= CRC_INIT;
      phase         <= '0;
      len_cnt       <= '0;
      bus.out_vld   <= 1'b0;
      bus.out       <= '0;
      bus.frame_end <= 1'b0;
      bus.fcs_ok    <= 1'b0;
      bus.runt      <= 1'b0;
      bus.align_err <= 1'b0;
      bus.too_long  <= 1'b0;
      bus.len       <= '0;
    end else begin
      bus.out_vld   <= emit;
      bus.frame_end <= finish;
      if (emit) bus.out <= dly_out;
      crc <= crc_next;
      if (finish) begin
        bus.fcs_ok    <= (crc_next == CRC_RESIDUE) && !runt_next && !align_next;
        bus.runt      <= runt_next;
        bus.align_err <= align_next;
        bus.too_long  <= len_next == LEN_W'(MAX_BYTES);
        bus.len       <= len_next;
        state         <= IDLE;
        phase         <= '0;
        len_cnt       <= '0;
      end else if (bus.in_vld) begin
        phase   <= phase_next;
        len_cnt <= len_next;
        if (fill_next == FILL_W'(FCS_DIBITS)) state <= STREAM;
        else                                  state <= FILL;
      end
    end
  end

endmodule

// File: tb/tb_rx_fcs_check.sv
// Randomized self-checking bench for rx_fcs_check against a byte-level FCS model.
module tb_rx_fcs_check;

  localparam int unsigned MAXB = 20;

  typedef logic [1:0] dib_q_t[$];
  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic        ok;
    logic        runt;
    logic        align;
    logic        tl;
    int unsigned len;
  } stat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rx_fcs_check_if #(.LEN_W(11)) bus();

  rx_fcs_check #(.MAX_BYTES(MAXB), .LEN_W(11)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  dib_q_t      exp_out;
  stat_t       exp_stat[$];
  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Standard CRC-32 (reflected, init all-ones, final inversion).
  function automatic logic [31:0] crc32(input byte_q_t b);
    logic [31:0] c = 32'hffffffff;
    foreach (b[i]) begin
      c ^= {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic byte_q_t with_fcs(input byte_q_t p);
    byte_q_t     r = p;
    logic [31:0] c = crc32(p);
    for (int i = 0; i < 4; i++) r.push_back(c[8*i +: 8]);
    return r;
  endfunction

  function automatic dib_q_t to_dibits(input byte_q_t b);
    dib_q_t d;
    foreach (b[i]) for (int k = 0; k < 4; k++) d.push_back(b[i][2*k +: 2]);
    return d;
  endfunction

  // Frame of n dibits: last 16 are FCS, first n-16 are payload; FCS valid iff
  // the trailing 4 bytes are the CRC-32 of the preceding bytes.
  task automatic predict(input dib_q_t fr);
    int unsigned n = fr.size();
    int unsigned nb;
    stat_t       s;
    byte_q_t     pay;
    logic [31:0] fcs;
    for (int i = 0; i + 16 < n; i++) exp_out.push_back(fr[i]);
    nb      = (n >= 16) ? (n - 16) / 4 : 0;
    s.runt  = n < 16;
    s.align = (n % 4) != 0;
    s.len   = (nb > MAXB) ? MAXB : nb;
    s.tl    = nb >= MAXB;
    s.ok    = 1'b0;
    if (!s.runt && !s.align) begin
      for (int i = 0; i < int'(n / 4); i++) begin
        logic [7:0] by = {fr[4*i+3], fr[4*i+2], fr[4*i+1], fr[4*i]};
        if (i < int'(n / 4) - 4) pay.push_back(by);
        else fcs[8*(i - (int'(n / 4) - 4)) +: 8] = by;
      end
      s.ok = crc32(pay) == fcs;
    end
    exp_stat.push_back(s);
  endtask

  task automatic idle(input int unsigned cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
      bus.in_vld = 1'b0; bus.in_done = 1'b0; bus.in = '0;
    end
  endtask

  task automatic send(input dib_q_t fr, input bit gaps, input bit done_last);
    predict(fr);
    foreach (fr[i]) begin
      if (gaps && i > 0 && ($urandom % 2 == 1)) idle($urandom_range(1, 3));
      @(posedge clk); #1;
      bus.in_vld  = 1'b1;
      bus.in      = fr[i];
      bus.in_done = done_last && (i == fr.size() - 1);
    end
    if (!done_last) begin
      @(posedge clk); #1;
      bus.in_vld = 1'b0; bus.in_done = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] e;
    stat_t      s;
    if (!reset) begin
      if (bus.out_vld) begin
        if (exp_out.size() == 0) check("spurious_out_vld", 1, 0);
        else begin
          e = exp_out.pop_front();
          check("out_dibit", bus.out, e);
        end
      end
      if (bus.frame_end) begin
        if (exp_stat.size() == 0) check("spurious_frame_end", 1, 0);
        else begin
          s = exp_stat.pop_front();
          check("fcs_ok", bus.fcs_ok, s.ok);
          check("runt", bus.runt, s.runt);
          check("align_err", bus.align_err, s.align);
          check("too_long", bus.too_long, s.tl);
          check("len", bus.len, s.len);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_vld"}, bus.out_vld, 0);
    check({tag, "_frame_end"}, bus.frame_end, 0);
    check({tag, "_fcs_ok"}, bus.fcs_ok, 0);
    check({tag, "_runt"}, bus.runt, 0);
    check({tag, "_align_err"}, bus.align_err, 0);
    check({tag, "_too_long"}, bus.too_long, 0);
    check({tag, "_len"}, bus.len, 0);
  endtask

  initial begin
    byte_q_t p9, good, bad, rp;
    dib_q_t  d, dx;
    string   s9 = "123456789";

    reset = 1'b1;
    bus.in_vld = 1'b0; bus.in = '0; bus.in_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    #1 reset = 1'b0;

    for (int i = 0; i < 9; i++) p9.push_back(s9[i]);
    good = with_fcs(p9);
    check("ref_fcs", {good[12], good[11], good[10], good[9]}, 32'hcbf43926);

    idle(2);
    send(to_dibits(good), 1'b0, 1'b0);
    idle(4);

    bad = good;
    bad[3] = bad[3] ^ 8'h01;
    send(to_dibits(bad), 1'b0, 1'b0);
    idle(4);

    d = to_dibits(good);
    dx = d[0:11];
    send(dx, 1'b0, 1'b0);
    idle(4);

    dx = d;
    dx.push_back(2'b10);
    send(dx, 1'b0, 1'b0);
    idle(4);

    send(d, 1'b1, 1'b1);
    idle(4);

    // Abort mid-frame: 20 dibits, drain the 4 emitted ones, then reset.
    for (int i = 16; i < 20; i++) exp_out.push_back(d[i - 16]);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      bus.in_vld = 1'b1; bus.in = d[i]; bus.in_done = 1'b0;
    end
    idle(2);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort");
    @(posedge clk); #1 reset = 1'b0;
    idle(1);
    check("abort_no_pending_status", exp_stat.size(), 0);

    send(d, 1'b0, 1'b1);
    send(d, 1'b0, 1'b1);
    idle(4);

    for (int f = 0; f < 12; f++) begin
      int unsigned mode = $urandom_range(0, 3);
      rp.delete();
      repeat ($urandom_range(0, 26)) rp.push_back(8'($urandom));
      dx = to_dibits(with_fcs(rp));
      if (mode == 1) begin
        int unsigned pos = $urandom_range(0, dx.size() - 1);
        dx[pos] = dx[pos] ^ 2'($urandom_range(1, 3));
      end else if (mode == 2) begin
        repeat ($urandom_range(1, 3)) dx.push_back(2'($urandom));
      end else if (mode == 3) begin
        dx = dx[0:$urandom_range(0, 14)];
      end
      send(dx, 1'($urandom), 1'($urandom));
      if ($urandom % 2 == 1) idle($urandom_range(1, 4));
    end
    idle(4);

    for (int i = 0; i < 200 && (exp_out.size() != 0 || exp_stat.size() != 0); i++) @(posedge clk);
    check("out_dibits_left", exp_out.size(), 0);
    check("frame_ends_left", exp_stat.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
